stopwatch_ctrl: RTL and testbench

- Button/mode controller that sequences the stopwatch counter block.
- Debounces the two raw stopwatch buttons and turns them into single-cycle Start_S/Stop_S/Reset_S commands.
- Runs a lap (split) freeze of the displayed time.
- Sits between the panel buttons and the stopwatch counter; its display outputs feed the display mux.

---
 rtl/stopwatch_ctrl_if.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Panel-side bundle of the stopwatch controller: mode/button inputs, live time,
// command pulses and the display/status outputs.
interface stopwatch_ctrl_if;
  logic       Control;
  logic       Btn_SS;
  logic       Btn_LR;
  logic [3:0] Hours_S;
  logic [5:0] Mins_S;
  logic [5:0] Secs_S;
  logic [9:0] MSecs_S;
  logic       Start_S;
  logic       Stop_S;
  logic       Reset_S;
  logic [3:0] Disp_Hours;
  logic [5:0] Disp_Mins;
  logic [5:0] Disp_Secs;
  logic [9:0] Disp_MSecs;
  logic       Lap_Active;
  logic [1:0] State;

  modport master (
    output Control, Btn_SS, Btn_LR, Hours_S, Mins_S, Secs_S, MSecs_S,
    input  Start_S, Stop_S, Reset_S, Disp_Hours, Disp_Mins, Disp_Secs,
           Disp_MSecs, Lap_Active, State
  );

  modport slave (
    input  Control, Btn_SS, Btn_LR, Hours_S, Mins_S, Secs_S, MSecs_S,
    output Start_S, Stop_S, Reset_S, Disp_Hours, Disp_Mins, Disp_Secs,
           Disp_MSecs, Lap_Active, State
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button/mode controller: debounces start/stop and lap/reset buttons,
// sequences the counter with one-cycle commands and freezes the display on a lap.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic           Clock_1MSec,
  input  logic           Reset,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_MS);

  // bit 0 = start/stop button, bit 1 = lap/reset button
  logic [1:0] btn_raw;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] deb_p2;
  logic [1:0] prev_p3;
  logic [7:0] db_cnt [2];

  logic [1:0] press;
  logic       ss_ev;
  logic       lr_ev;

  state_t     state;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_clear;
  logic       lap_active;
  logic [3:0] lap_hours;
  logic [5:0] lap_mins;
  logic [5:0] lap_secs;
  logic [9:0] lap_msecs;

  assign btn_raw = {sw.Btn_LR, sw.Btn_SS};

  // Stage p0/p1: synchronizer; p2: debounced level; p3: previous debounced level
  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      deb_p2    <= '0;
      prev_p3   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      prev_p3 <= deb_p2;
      for (int b = 0; b < 2; b++) begin
        // Any cycle agreeing with the accepted level restarts the hold count
        if (sync_p1[b] == deb_p2[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LIM) begin
          deb_p2[b] <= ~deb_p2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 8'd1;
        end
      end
    end
  end

  assign press = deb_p2 & ~prev_p3;
  assign ss_ev = press[0] & sw.Control;
  assign lr_ev = press[1] & sw.Control & ~press[0];

  // Stage p4: mode FSM with registered command pulses and lap capture
  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cmd_start  <= 1'b0;
      cmd_stop   <= 1'b0;
      cmd_clear  <= 1'b0;
      lap_active <= 1'b0;
      lap_hours  <= '0;
      lap_mins   <= '0;
      lap_secs   <= '0;
      lap_msecs  <= '0;
    end else begin
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_clear <= 1'b0;
      if (ss_ev) begin
        case (state)
          RUN, LAP: begin
            cmd_stop   <= 1'b1;
            state      <= STOP;
            lap_active <= 1'b0;
          end
          default: begin
            cmd_start  <= 1'b1;
            state      <= RUN;
            lap_active <= 1'b0;
          end
        endcase
      end else if (lr_ev) begin
        case (state)
          IDLE: begin
            cmd_clear <= 1'b1;
            lap_hours <= '0;
            lap_mins  <= '0;
            lap_secs  <= '0;
            lap_msecs <= '0;
          end
          RUN: begin
            lap_hours  <= sw.Hours_S;
            lap_mins   <= sw.Mins_S;
            lap_secs   <= sw.Secs_S;
            lap_msecs  <= sw.MSecs_S;
            state      <= LAP;
            lap_active <= 1'b1;
          end
          LAP: begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
          default: begin
            cmd_clear  <= 1'b1;
            lap_hours  <= '0;
            lap_mins   <= '0;
            lap_secs   <= '0;
            lap_msecs  <= '0;
            state      <= IDLE;
            lap_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sw.Start_S    = cmd_start;
  assign sw.Stop_S     = cmd_stop;
  assign sw.Reset_S    = cmd_clear;
  assign sw.Lap_Active = lap_active;
  assign sw.State      = state;

  // Display is a live pass-through except while frozen on a lap
  assign sw.Disp_Hours = lap_active ? lap_hours : sw.Hours_S;
  assign sw.Disp_Mins  = lap_active ? lap_mins  : sw.Mins_S;
  assign sw.Disp_Secs  = lap_active ? lap_secs  : sw.Secs_S;
  assign sw.Disp_MSecs = lap_active ? lap_msecs : sw.MSecs_S;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized buttons/mode/reset,
// checked every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;
  localparam int N = 4;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DEBOUNCE_MS(N)) dut (
    .Clock_1MSec(clk),
    .Reset      (rst),
    .sw         (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bq_t h_ss, h_lr;
  bit  deb_ss, deb_lr, prev_ss, prev_lr;
  int  m_state;
  bit  m_start, m_stop, m_clr;
  int  lap_h, lap_m, lap_s, lap_ms;
  int  n_start = 0, n_stop = 0, n_clr = 0;

  // Accept a new level once the last N+1 synchronized samples all disagree
  // with the accepted one; samples reach the comparison two edges late.
  function automatic bit flips(input bq_t q, input bit lvl);
    int sz = q.size();
    if (sz - 2 - N < 0) return 1'b0;
    for (int i = sz - 2 - N; i <= sz - 2; i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit ev_ss, ev_lr;
    if (rst) begin
      h_ss = {1'b0, 1'b0};
      h_lr = {1'b0, 1'b0};
      deb_ss = 0; deb_lr = 0; prev_ss = 0; prev_lr = 0;
      m_state = 0; m_start = 0; m_stop = 0; m_clr = 0;
      lap_h = 0; lap_m = 0; lap_s = 0; lap_ms = 0;
    end else begin
      ev_ss = deb_ss && !prev_ss && bus.Control;
      ev_lr = deb_lr && !prev_lr && bus.Control && !ev_ss;
      m_start = 0; m_stop = 0; m_clr = 0;
      if (ev_ss) begin
        if (m_state == 1 || m_state == 2) begin m_stop = 1; m_state = 3; end
        else begin m_start = 1; m_state = 1; end
      end else if (ev_lr) begin
        case (m_state)
          0: begin m_clr = 1; lap_h = 0; lap_m = 0; lap_s = 0; lap_ms = 0; end
          1: begin
            lap_h = bus.Hours_S; lap_m = bus.Mins_S;
            lap_s = bus.Secs_S;  lap_ms = bus.MSecs_S;
            m_state = 2;
          end
          2: m_state = 1;
          default: begin
            m_clr = 1; lap_h = 0; lap_m = 0; lap_s = 0; lap_ms = 0; m_state = 0;
          end
        endcase
      end
      prev_ss = deb_ss;
      prev_lr = deb_lr;
      if (flips(h_ss, deb_ss)) deb_ss = !deb_ss;
      if (flips(h_lr, deb_lr)) deb_lr = !deb_lr;
      h_ss.push_back(bus.Btn_SS);
      h_lr.push_back(bus.Btn_LR);
      if (h_ss.size() > N + 3) void'(h_ss.pop_front());
      if (h_lr.size() > N + 3) void'(h_lr.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    bit lap;
    @(posedge clk);
    #1;
    lap = (m_state == 2);
    chk("state",   32'(bus.State),      32'(m_state));
    chk("start",   32'(bus.Start_S),    32'(m_start));
    chk("stop",    32'(bus.Stop_S),     32'(m_stop));
    chk("clear",   32'(bus.Reset_S),    32'(m_clr));
    chk("lap",     32'(bus.Lap_Active), 32'(lap));
    chk("d_hours", 32'(bus.Disp_Hours), lap ? 32'(lap_h)  : 32'(bus.Hours_S));
    chk("d_mins",  32'(bus.Disp_Mins),  lap ? 32'(lap_m)  : 32'(bus.Mins_S));
    chk("d_secs",  32'(bus.Disp_Secs),  lap ? 32'(lap_s)  : 32'(bus.Secs_S));
    chk("d_msecs", 32'(bus.Disp_MSecs), lap ? 32'(lap_ms) : 32'(bus.MSecs_S));
    n_start += int'(bus.Start_S);
    n_stop  += int'(bus.Stop_S);
    n_clr   += int'(bus.Reset_S);
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_live(input int h, input int m, input int s, input int ms);
    bus.Hours_S = 4'(h); bus.Mins_S = 6'(m); bus.Secs_S = 6'(s); bus.MSecs_S = 10'(ms);
  endtask

  int s0, s1, s2;
  int cd_ss, cd_lr, cd_ctl;

  initial begin
    rst = 1'b1;
    bus.Control = 1'b1; bus.Btn_SS = 1'b0; bus.Btn_LR = 1'b0;
    set_live(0, 0, 0, 0);

    // 1: reset state, then exact press latency
    hold(3);
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_start", 32'(bus.Start_S), 32'd0);
    chk("rst_lap",   32'(bus.Lap_Active), 32'd0);
    rst = 1'b0;
    hold(2);
    s0 = n_start + n_stop + n_clr;
    bus.Btn_SS = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("t1_start", 32'(bus.Start_S), 32'(i == N + 3));
      chk("t1_state", 32'(bus.State), (i >= N + 3) ? 32'd1 : 32'd0);
    end
    chk("t1_pulses", 32'(n_start + n_stop + n_clr - s0), 32'd1);
    bus.Btn_SS = 1'b0;
    hold(2 * N + 4);

    // 2: bouncing press from IDLE yields one start
    rst = 1'b1; hold(2); rst = 1'b0; hold(2);
    s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      bus.Btn_SS = (i % 2 == 0);
      hold(1);
    end
    bus.Btn_SS = 1'b1;
    hold(N + 10);
    chk("t2_starts", 32'(n_start - s0), 32'd1);
    chk("t2_state",  32'(bus.State), 32'd1);
    bus.Btn_SS = 1'b0;
    hold(N + 6);

    // 3: lap freeze and release
    s0 = n_start + n_stop + n_clr;
    set_live(0, 0, 12, 345);
    bus.Btn_LR = 1'b1;
    hold(N + 8);
    set_live(1, 2, 3, 4);
    hold(1);
    chk("t3_lap",   32'(bus.Lap_Active), 32'd1);
    chk("t3_state", 32'(bus.State), 32'd2);
    chk("t3_h",     32'(bus.Disp_Hours), 32'd0);
    chk("t3_m",     32'(bus.Disp_Mins),  32'd0);
    chk("t3_s",     32'(bus.Disp_Secs),  32'd12);
    chk("t3_ms",    32'(bus.Disp_MSecs), 32'd345);
    bus.Btn_LR = 1'b0;
    hold(N + 6);
    bus.Btn_LR = 1'b1;
    hold(N + 8);
    set_live(5, 6, 7, 999);
    hold(1);
    chk("t3_state2", 32'(bus.State), 32'd1);
    chk("t3_lap2",   32'(bus.Lap_Active), 32'd0);
    chk("t3_live_ms", 32'(bus.Disp_MSecs), 32'd999);
    chk("t3_pulses", 32'(n_start + n_stop + n_clr - s0), 32'd0);
    bus.Btn_LR = 1'b0;
    hold(N + 6);

    // 4: stop then clear
    s0 = n_stop; s1 = n_clr;
    bus.Btn_SS = 1'b1; hold(N + 8); bus.Btn_SS = 1'b0; hold(N + 6);
    chk("t4_stops", 32'(n_stop - s0), 32'd1);
    chk("t4_state", 32'(bus.State), 32'd3);
    bus.Btn_LR = 1'b1; hold(N + 8); bus.Btn_LR = 1'b0; hold(N + 6);
    chk("t4_clears", 32'(n_clr - s1), 32'd1);
    chk("t4_state2", 32'(bus.State), 32'd0);

    // 5: simultaneous presses, start/stop wins
    s0 = n_start; s1 = n_clr;
    bus.Btn_SS = 1'b1; bus.Btn_LR = 1'b1;
    hold(N + 8);
    bus.Btn_SS = 1'b0; bus.Btn_LR = 1'b0;
    hold(N + 6);
    chk("t5_starts", 32'(n_start - s0), 32'd1);
    chk("t5_clears", 32'(n_clr - s1), 32'd0);
    chk("t5_state",  32'(bus.State), 32'd1);

    // 6: gated press is lost; async reset aborts a pending press
    s0 = n_start + n_stop + n_clr;
    bus.Control = 1'b0;
    bus.Btn_SS = 1'b1; hold(N + 8); bus.Btn_SS = 1'b0; hold(N + 6);
    bus.Control = 1'b1;
    hold(N + 8);
    chk("t6_state", 32'(bus.State), 32'd1);
    chk("t6_pulses", 32'(n_start + n_stop + n_clr - s0), 32'd0);
    bus.Btn_LR = 1'b1;
    hold(N - 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(bus.State), 32'd0);
    chk("t6_rst_cmds",  32'({bus.Start_S, bus.Stop_S, bus.Reset_S}), 32'd0);
    chk("t6_rst_lap",   32'(bus.Lap_Active), 32'd0);
    bus.Btn_LR = 1'b0;
    hold(2);
    rst = 1'b0;
    s2 = n_start + n_stop + n_clr;
    hold(15);
    chk("t6_after", 32'(n_start + n_stop + n_clr - s2), 32'd0);
    chk("t6_state2", 32'(bus.State), 32'd0);

    // Randomized buttons with bounce, mode toggling and occasional async reset
    cd_ss = 3; cd_lr = 7; cd_ctl = 40;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
      set_live(int'($urandom_range(15)), int'($urandom_range(59)),
               int'($urandom_range(59)), int'($urandom_range(999)));
      cd_ss = cd_ss - 1;
      if (cd_ss <= 0) begin
        bus.Btn_SS = !bus.Btn_SS;
        cd_ss = ($urandom_range(9) < 4) ? int'($urandom_range(3, 1)) : int'($urandom_range(N + 15, N + 2));
      end
      cd_lr = cd_lr - 1;
      if (cd_lr <= 0) begin
        bus.Btn_LR = !bus.Btn_LR;
        cd_lr = ($urandom_range(9) < 4) ? int'($urandom_range(3, 1)) : int'($urandom_range(N + 15, N + 2));
      end
      cd_ctl = cd_ctl - 1;
      if (cd_ctl <= 0) begin
        bus.Control = !bus.Control;
        cd_ctl = bus.Control ? int'($urandom_range(80, 20)) : int'($urandom_range(20, 3));
      end
    end
    rst = 1'b0;
    hold(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
